quotient_bcd_converter: RTL and testbench

//  Downstream stage of integer_divider. Takes the unsigned binary quotient, converts it to packed
//  BCD digits with a multi-cycle shift-add-3 (double-dabble) FSM, and hands the result to the

---
 rtl/div_pkg.sv | 27 ++
 rtl/bcd_add3.sv | 11 +
 rtl/quotient_bcd_converter.sv | 91 +++++++++
 tb/tb_quotient_bcd_converter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the divider/BCD report path
package div_pkg;

  localparam int BCD_NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Smallest digit count whose decimal range covers every qw-bit unsigned value.
  function automatic int bcd_digits(input int qw);
    longint lim;
    longint pw;
    int     d;
    lim = longint'(1) << qw;
    pw  = 10;
    d   = 1;
    while (pw < lim) begin
      pw = pw * 10;
      d  = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble corrector (add 3 when nibble >= 5)
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] nib_adj
);

  always_comb begin
    nib_adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

endmodule

// File: rtl/quotient_bcd_converter.sv
// rtl/quotient_bcd_converter.sv - binary quotient to packed BCD, one conversion in flight
module quotient_bcd_converter
  import div_pkg::*;
#(
  parameter int QW     = 8,
  parameter int DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [QW-1:0]                in_quot,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BCD_NIBBLE*DIGITS-1:0] out_bcd,
  output logic                         busy
);

  localparam int BW = BCD_NIBBLE * DIGITS;
  localparam int CW = $clog2(QW + 1);

  if (DIGITS < bcd_digits(QW)) begin : g_digits_check
    $error("quotient_bcd_converter: DIGITS too small for QW");
  end

  conv_state_t   state, state_next;
  logic [QW-1:0] bin;
  logic [BW-1:0] bcd;
  logic [BW-1:0] bcd_adj;
  logic [BW-1:0] bcd_shifted;
  logic [BW-1:0] result;
  logic [CW-1:0] cnt;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nib     (bcd[i*BCD_NIBBLE +: BCD_NIBBLE]),
      .nib_adj (bcd_adj[i*BCD_NIBBLE +: BCD_NIBBLE])
    );
  end

  // Correction happens first, then the bin MSB is shifted into the units digit.
  assign bcd_shifted = BW'({bcd_adj, bin[QW-1]});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    busy      = (state == SHIFT);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        bin <= in_quot;
        bcd <= '0;
        cnt <= CW'(QW);
      end
    end else if (state == SHIFT) begin
      bin <= bin << 1;
      bcd <= bcd_shifted;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) result <= bcd_shifted;
    end
  end

  // Result register keeps the last conversion visible outside DONE.
  assign out_bcd = result;

endmodule

// File: tb/tb_quotient_bcd_converter.sv
// tb/tb_quotient_bcd_converter.sv - directed self-checking bench for quotient_bcd_converter
module tb_quotient_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_quot;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic        busy;

  logic        b_valid;
  logic        b_ready;
  logic [2:0]  b_quot;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [3:0]  b_out_bcd;
  logic        b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  quotient_bcd_converter #(.QW(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_quot   (in_quot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  quotient_bcd_converter #(.QW(3), .DIGITS(1)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_valid),
    .in_ready  (b_ready),
    .in_quot   (b_quot),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_bcd   (b_out_bcd),
    .busy      (b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [7:0] v);
    in_valid = 1'b1;
    in_quot  = v;
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_quot  = 8'hxx;
  endtask

  task automatic wait_done_a(output logic [11:0] res, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
    res = out_bcd;
  endtask

  task automatic conv_a(input logic [7:0] v, output logic [11:0] res, output int lat);
    start_a(v);
    wait_done_a(res, lat);
  endtask

  task automatic conv_b(input logic [2:0] v, output logic [3:0] res);
    int n;
    b_valid = 1'b1;
    b_quot  = v;
    step();
    b_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 20) begin
      step();
      n++;
    end
    if (!b_out_valid) chk("timeout_b_out_valid", 32'(b_out_valid), 32'd1);
    chk("b_latency", 32'(n), 32'd3);
    res = b_out_bcd;
    step();
  endtask

  logic [11:0] res;
  logic [3:0]  res_b;
  int          lat;
  int          seen;
  string       ref_s;

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_quot     = 8'd0;
    out_ready   = 1'b0;
    b_valid     = 1'b0;
    b_quot      = 3'd0;
    b_out_ready = 1'b1;
    step();
    step();
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_bcd", 32'(out_bcd), 32'h000);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Max value, latency and return to IDLE after the handshake.
    out_ready = 1'b1;
    conv_a(8'd255, res, lat);
    chk("lat_255", 32'(lat), 32'd8);
    chk("bcd_255", 32'(res), 32'h255);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("idle_in_ready_255", 32'(in_ready), 32'd1);
    chk("idle_out_valid_255", 32'(out_valid), 32'd0);
    chk("hold_bcd_idle", 32'(out_bcd), 32'h255);

    conv_a(8'd0, res, lat);
    chk("lat_0", 32'(lat), 32'd8);
    chk("bcd_0", 32'(res), 32'h000);
    step();
    conv_a(8'd99, res, lat);
    chk("lat_99", 32'(lat), 32'd8);
    chk("bcd_99", 32'(res), 32'h099);
    step();
    conv_a(8'd100, res, lat);
    chk("lat_100", 32'(lat), 32'd8);
    chk("bcd_100", 32'(res), 32'h100);
    step();

    // Back-pressure.
    out_ready = 1'b0;
    conv_a(8'd173, res, lat);
    chk("bcd_173", 32'(res), 32'h173);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_bcd", 32'(out_bcd), 32'h173);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Second pulse mid-conversion is ignored.
    start_a(8'd150);
    step();
    in_valid = 1'b1;
    in_quot  = 8'd7;
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    step();
    in_valid = 1'b0;
    wait_done_a(res, lat);
    chk("bcd_first_kept", 32'(res), 32'h150);
    step();
    conv_a(8'd7, res, lat);
    chk("bcd_7", 32'(res), 32'h007);
    step();

    // Reset in the 4th SHIFT cycle aborts the conversion.
    start_a(8'd200);
    step();
    step();
    step();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_bcd", 32'(out_bcd), 32'h000);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);
    conv_a(8'd42, res, lat);
    chk("bcd_42", 32'(res), 32'h042);
    step();

    // Small instance fed with divider quotients.
    conv_b(3'(25 / 4), res_b);
    chk("div_25_4", 32'(res_b), 32'h6);
    conv_b(3'(23 / 6), res_b);
    chk("div_23_6", 32'(res_b), 32'h3);
    conv_b(3'(20 / 5), res_b);
    chk("div_20_5", 32'(res_b), 32'h4);
    conv_b(3'(13 / 7), res_b);
    chk("div_13_7", 32'(res_b), 32'h1);
    for (int v = 0; v < 8; v++) begin
      conv_b(3'(v), res_b);
      ref_s = $sformatf("%0d", v);
      chk("sweep_small", 32'(res_b), 32'(ref_s.atohex()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
